// File: rtl/prbs_frame_gen_pkg.sv
// rtl/prbs_frame_gen_pkg.sv - shared state encoding, PRBS7 taps and default words
package prbs_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  // x^7 + x^6 + 1 in Fibonacci form: feedback taps on s[6] and s[5]
  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;

  localparam logic [31:0] DEF_HEADER    = 32'hBCBC_BCBC;
  localparam logic [31:0] DEF_IDLE_WORD = 32'h5555_5555;

endpackage

// File: rtl/prbs_frame_gen_if.sv
// rtl/prbs_frame_gen_if.sv - control inputs and framed data outputs of the pattern source
interface prbs_frame_gen_if;

  logic        enable;
  logic        mode;
  logic        inject_err;
  logic [31:0] dout;
  logic        frame_start;
  logic        payload_vld;
  logic        err_injected;

  // generator side
  modport master (
    input  enable, mode, inject_err,
    output dout, frame_start, payload_vld, err_injected
  );

  // driver / consumer side
  modport slave (
    output enable, mode, inject_err,
    input  dout, frame_start, payload_vld, err_injected
  );

endinterface

// File: rtl/prbs_frame_gen_prbs7_par32.sv
// rtl/prbs_frame_gen_prbs7_par32.sv - combinational 32-step PRBS7 advance, shared with the rx checker
module prbs7_par32
  import prbs_frame_gen_pkg::*;
(
  input  logic [6:0]  i_state,
  output logic [6:0]  o_state,
  output logic [31:0] o_word
);

  // unroll 32 serial steps; the first generated bit lands in the MSB
  always_comb begin
    logic [6:0] w_s;
    logic       w_new;
    w_s    = i_state;
    w_new  = 1'b0;
    o_word = '0;
    for (int i = 31; i >= 0; i--) begin
      w_new     = w_s[PRBS_TAP_HI] ^ w_s[PRBS_TAP_LO];
      o_word[i] = w_new;
      w_s       = {w_s[5:0], w_new};
    end
    o_state = w_s;
  end

endmodule

// File: rtl/prbs_frame_gen.sv
// rtl/prbs_frame_gen.sv - framed PRBS7 / counter test-pattern source with error injection
module prbs_frame_gen
  import prbs_frame_gen_pkg::*;
#(
  parameter int          FRAME_LEN = 16,
  parameter logic [31:0] HEADER    = DEF_HEADER,
  parameter logic [31:0] IDLE_WORD = DEF_IDLE_WORD,
  parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  prbs_frame_gen_if.master  io_bus
);

  localparam int                CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic [6:0]        r_prbs;
  logic [31:0]       r_ctr;
  logic              r_pend;
  logic [31:0]       r_dout;
  logic              r_frame_start;
  logic              r_payload_vld;
  logic              r_err_injected;

  logic [6:0]        w_prbs_nxt;
  logic [31:0]       w_prbs_word;
  logic [31:0]       w_pay_word;
  logic              w_last;
  logic              w_corrupt;

  prbs7_par32 u_prbs (
    .i_state (r_prbs),
    .o_state (w_prbs_nxt),
    .o_word  (w_prbs_word)
  );

  // next-state: frames always run to completion, enable only checked at the boundary
  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_cnt == CNT_LAST);
    w_pay_word  = r_mode ? r_ctr : w_prbs_word;
    w_corrupt   = (r_state == ST_PAY) && r_pend;
    case (r_state)
      ST_IDLE: if (io_bus.enable) w_state_nxt = ST_HDR;
      ST_HDR:  w_state_nxt = ST_PAY;
      ST_PAY:  if (w_last) w_state_nxt = io_bus.enable ? ST_HDR : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // registered outputs, pattern generators and pending-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_mode         <= 1'b0;
      r_prbs         <= PRBS_SEED;
      r_ctr          <= '0;
      r_pend         <= 1'b0;
      r_dout         <= IDLE_WORD;
      r_frame_start  <= 1'b0;
      r_payload_vld  <= 1'b0;
      r_err_injected <= 1'b0;
    end else begin
      // a pulse landing on the corrupted word re-arms for the following payload word
      r_pend         <= io_bus.inject_err | (r_pend & ~w_corrupt);
      r_dout         <= IDLE_WORD;
      r_frame_start  <= 1'b0;
      r_payload_vld  <= 1'b0;
      r_err_injected <= 1'b0;
      case (r_state)
        ST_HDR: begin
          r_dout        <= HEADER;
          r_frame_start <= 1'b1;
          r_mode        <= io_bus.mode;
          r_cnt         <= CNT_W'(1);
        end
        ST_PAY: begin
          // corruption touches only the output word, never the generator state
          r_dout         <= w_pay_word ^ {31'd0, w_corrupt};
          r_payload_vld  <= 1'b1;
          r_err_injected <= w_corrupt;
          r_cnt          <= r_cnt + CNT_W'(1);
          if (r_mode) r_ctr  <= r_ctr + 32'd1;
          else        r_prbs <= w_prbs_nxt;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.dout         = r_dout;
  assign io_bus.frame_start  = r_frame_start;
  assign io_bus.payload_vld  = r_payload_vld;
  assign io_bus.err_injected = r_err_injected;

endmodule
